// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, fed LSB-first
// from operand shift registers; result and carry-out are presented with a done pulse.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sr_q;
   logic [WIDTH-1:0] b_sr_q;
   logic [WIDTH-1:0] sum_sr_q;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_sr_d;

   // The single full-adder cell sees the current LSB pair and the stored carry.
   assign fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign fa_c     = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
   assign sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sr_q  <= a_in;
                  b_sr_q  <= b_in;
                  carry_q <= cin_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               carry_q  <= fa_c;
               a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
               b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
               sum_sr_q <= sum_sr_d;
               cnt_q    <= cnt_q + CNT_W'(1);
               // Last bit: the final sum bit is folded in directly rather than via sum_sr_q.
               if (cnt_q == LAST_BIT) begin
                  sum_q   <= sum_sr_d;
                  cout_q  <= fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum_out  = sum_q;
   assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder: WIDTH=8 directed/random runs
// and an exhaustive WIDTH=2 sweep, both compared against plain a+b+cin arithmetic.
module tb_serial_adder;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       cin_in;
   logic       busy;
   logic       done;
   logic [7:0] sum_out;
   logic       cout_out;

   logic       start2;
   logic [1:0] a2;
   logic [1:0] b2;
   logic       cin2;
   logic       busy2;
   logic       done2;
   logic [1:0] sum2;
   logic       cout2;

   int n_checks = 0;
   int n_pass   = 0;

   serial_adder #(.WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .cin_in(cin_in), .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
   );

   serial_adder #(.WIDTH(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2),
      .cin_in(cin2), .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference: full-precision sum of the operands, nine bits wide.
   function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int unsigned t;
      t = int'(a) + int'(b) + int'(c);
      return 9'(t);
   endfunction

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c, input bit inject);
      logic [8:0] exp;
      int k;
      int busy_cnt;
      int extra_done;
      exp = ref_add8(a, b, c);
      @(negedge clk);
      a_in = a; b_in = b; cin_in = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
      k = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
         if (busy) busy_cnt++;
         if (inject && k == 3) begin
            start = 1'b1; a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
         end
         if (inject && k == 4) start = 1'b0;
      end
      check("latency", 64'(k), 64'd8);
      check("busy_cycles", 64'(busy_cnt), 64'd8);
      check("result", {55'd0, cout_out, sum_out}, {55'd0, exp});
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      if (inject) begin
         extra_done = 0;
         for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
            if ({cout_out, sum_out} !== exp) extra_done += 100;
         end
         check("inject_no_extra_done_and_stable", 64'(extra_done), 64'd0);
      end
   endtask

   initial begin
      logic [8:0] exp;
      logic [2:0] exp2;
      int         k;
      int         dn;
      int         last_done;
      int         n_done;
      logic [8:0] hist [0:39];

      reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {60'd0, busy, done, cout_out, |sum_out}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases
      do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      check("5A+3C", {55'd0, cout_out, sum_out}, 64'h096);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      check("FF+01", {55'd0, cout_out, sum_out}, 64'h100);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      check("FF+FF+1", {55'd0, cout_out, sum_out}, 64'h1FF);

      // Second start during ADD must be ignored
      do_op(8'h5A, 8'h3C, 1'b0, 1'b1);
      check("inject_result", {55'd0, cout_out, sum_out}, 64'h096);

      // Asynchronous reset in the 4th ADD cycle
      @(negedge clk);
      a_in = 8'hC3; b_in = 8'h7E; cin_in = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("busy_before_reset", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check("reset_async", {60'd0, busy, done, cout_out, |sum_out}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done || busy) dn++;
      end
      check("no_done_after_reset", 64'(dn), 64'd0);
      do_op(8'h01, 8'h01, 1'b0, 1'b0);
      check("01+01_after_reset", {55'd0, cout_out, sum_out}, 64'h002);

      // start tied high: operand history indexed by edge number
      n_done = 0; last_done = -1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         start = 1'b1;
         a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
         hist[cyc] = ref_add8(a_in, b_in, cin_in);
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            check("tied_result", {55'd0, cout_out, sum_out},
                  (cyc >= 8) ? {55'd0, hist[cyc-8]} : 64'h1_0000);
            if (last_done >= 0) check("tied_spacing", 64'(cyc - last_done), 64'd10);
            last_done = cyc;
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("tied_done_count", 64'(n_done), 64'd3);
      k = 0;
      while ((busy || done) && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      @(posedge clk); #1;

      // Exhaustive WIDTH=2
      for (int v = 0; v < 32; v++) begin
         @(negedge clk);
         a2 = 2'(v >> 3); b2 = 2'(v >> 1); cin2 = 1'(v);
         exp2 = 3'(int'(a2) + int'(b2) + int'(cin2));
         start2 = 1'b1;
         @(posedge clk); #1;
         start2 = 1'b0;
         k = 0;
         while (!done2 && k < 10) begin
            @(posedge clk); #1;
            k++;
         end
         check("w2_latency", 64'(k), 64'd2);
         check("w2_result", {61'd0, cout2, sum2}, {61'd0, exp2});
         @(posedge clk); #1;
      end

      // Random WIDTH=8
      for (int v = 0; v < 1000; v++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         exp = ref_add8(ra, rb, rc);
         do_op(ra, rb, rc, 1'b0);
         check("rand_result", {55'd0, cout_out, sum_out}, {55'd0, exp});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
